// File: rtl/lfsr_checker.sv
// Checker for a 16-bit pattern generator: hunts for the sequence, locks after a
// run of predicted matches, then counts word and bit errors against a free-running reference.
module lfsr_checker #(
    parameter int LOCK_CNT = 4,
    parameter int LOSS_CNT = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] data_in,
    input  logic        valid_in,
    input  logic        clr_cnt,
    output logic        locked,
    output logic        err_pulse,
    output logic [15:0] err_count,
    output logic [15:0] bit_errs
);

    typedef enum logic {HUNT, LOCKED} state_t;

    localparam logic [4:0] LockThresh = 5'(LOCK_CNT);
    localparam logic [4:0] LossThresh = 5'(LOSS_CNT);

    state_t      state_q, state_d;
    logic [15:0] refWord_q, refWord_d;
    logic        havePrev_q, havePrev_d;
    logic [3:0]  run_q, run_d;
    logic        errPulse_q, errPulse_d;
    logic [15:0] errCount_q, errCount_d;
    logic [15:0] bitErrs_q, bitErrs_d;

    logic [15:0] expWord;
    logic        match;
    logic [4:0]  runInc;
    logic [4:0]  bitDiff;
    logic [16:0] bitSum;
    logic        errBeat;

    function automatic logic [15:0] nextWord(input logic [15:0] w);
        logic fb;
        fb = (w[15] ^ w[14] ^ w[12] ^ w[3]) | ~(w[15] | w[14] | w[12] | w[3]);
        return {w[14:0], fb};
    endfunction

    function automatic logic [4:0] popCount(input logic [15:0] v);
        logic [4:0] c;
        c = '0;
        for (int i = 0; i < 16; i++) c = c + {4'd0, v[i]};
        return c;
    endfunction

    always_comb begin
        expWord    = nextWord(refWord_q);
        match      = (data_in == expWord);
        runInc     = {1'b0, run_q} + 5'd1;
        bitDiff    = popCount(data_in ^ expWord);
        bitSum     = {1'b0, bitErrs_q} + {12'd0, bitDiff};
        errBeat    = valid_in && (state_q == LOCKED) && !match;

        state_d    = state_q;
        refWord_d  = refWord_q;
        havePrev_d = havePrev_q;
        run_d      = run_q;
        errPulse_d = 1'b0;
        errCount_d = errCount_q;
        bitErrs_d  = bitErrs_q;

        if (valid_in) begin
            case (state_q)
                HUNT: begin
                    // HUNT re-seeds from every received word so it tracks any phase.
                    refWord_d  = data_in;
                    havePrev_d = 1'b1;
                    if (!havePrev_q || !match) begin
                        run_d = '0;
                    end else if (runInc >= LockThresh) begin
                        state_d = LOCKED;
                        run_d   = '0;
                    end else begin
                        run_d = runInc[3:0];
                    end
                end
                LOCKED: begin
                    refWord_d = expWord;
                    if (match) begin
                        run_d = '0;
                    end else begin
                        errPulse_d = 1'b1;
                        if (runInc >= LossThresh) begin
                            state_d   = HUNT;
                            refWord_d = data_in;
                            run_d     = '0;
                        end else begin
                            run_d = runInc[3:0];
                        end
                    end
                end
                default: state_d = HUNT;
            endcase
        end

        if (clr_cnt) begin
            errCount_d = '0;
            bitErrs_d  = '0;
        end else if (errBeat) begin
            errCount_d = (errCount_q == 16'hFFFF) ? errCount_q : errCount_q + 16'd1;
            bitErrs_d  = bitSum[16] ? 16'hFFFF : bitSum[15:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= HUNT;
            refWord_q  <= '0;
            havePrev_q <= 1'b0;
            run_q      <= '0;
            errPulse_q <= 1'b0;
            errCount_q <= '0;
            bitErrs_q  <= '0;
        end else begin
            state_q    <= state_d;
            refWord_q  <= refWord_d;
            havePrev_q <= havePrev_d;
            run_q      <= run_d;
            errPulse_q <= errPulse_d;
            errCount_q <= errCount_d;
            bitErrs_q  <= bitErrs_d;
        end
    end

    assign locked    = (state_q == LOCKED);
    assign err_pulse = errPulse_q;
    assign err_count = errCount_q;
    assign bit_errs  = bitErrs_q;

endmodule

// File: tb/tb_lfsr_checker.sv
// Directed bench for lfsr_checker: lock acquisition, error counting, loss of lock,
// saturation, counter clear and asynchronous reset.
module tb_lfsr_checker;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] dataIn;
    logic        validIn;
    logic        clrCnt;
    logic        locked;
    logic        errPulse;
    logic [15:0] errCount;
    logic [15:0] bitErrs;

    int checkCount = 0;
    int passCount  = 0;
    logic [15:0] bref;
    logic [15:0] d;

    always #5 clk = ~clk;

    lfsr_checker #(.LOCK_CNT(4), .LOSS_CNT(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .data_in   (dataIn),
        .valid_in  (validIn),
        .clr_cnt   (clrCnt),
        .locked    (locked),
        .err_pulse (errPulse),
        .err_count (errCount),
        .bit_errs  (bitErrs)
    );

    function automatic logic [15:0] nextWord(input logic [15:0] w);
        logic fb;
        fb = (w[15] ^ w[14] ^ w[12] ^ w[3]) | ~(w[15] | w[14] | w[12] | w[3]);
        return {w[14:0], fb};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed === expected) passCount++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    endtask

    task automatic checkAll(input string tag, input logic lk, input logic ep,
                            input logic [15:0] ec, input logic [15:0] be);
        checkOutput({tag, ".locked"}, {31'd0, locked}, {31'd0, lk});
        checkOutput({tag, ".err_pulse"}, {31'd0, errPulse}, {31'd0, ep});
        checkOutput({tag, ".err_count"}, {16'd0, errCount}, {16'd0, ec});
        checkOutput({tag, ".bit_errs"}, {16'd0, bitErrs}, {16'd0, be});
    endtask

    task automatic applyStimulus(input logic v, input logic [15:0] data, input logic c);
        @(negedge clk);
        validIn = v;
        dataIn  = data;
        clrCnt  = c;
        @(posedge clk);
        #1;
        validIn = 1'b0;
        clrCnt  = 1'b0;
    endtask

    // Feeds a correct chain starting at start; locked is expected from beat lockAt onward.
    task automatic feedChain(input string tag, input logic [15:0] start, input int n,
                             input int lockAt, output logic [15:0] last);
        logic [15:0] w;
        w = start;
        for (int k = 1; k <= n; k++) begin
            applyStimulus(1'b1, w, 1'b0);
            checkOutput($sformatf("%s.beat%0d.locked", tag, k), {31'd0, locked}, {31'd0, (k >= lockAt)});
            last = w;
            w = nextWord(w);
        end
    endtask

    task automatic doReset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b0; validIn = 1'b0; clrCnt = 1'b0; dataIn = '0;
        #1 rst = 1'b1;
        #2 checkAll("reset", 1'b0, 1'b0, 16'h0000, 16'h0000);
        @(negedge clk);
        rst = 1'b0;

        // Acquire lock on 0003..003F
        feedChain("lock", 16'h0003, 5, 5, bref);
        checkAll("lock.done", 1'b1, 1'b0, 16'h0000, 16'h0000);

        // Single-bit error then recovery, with idle gaps
        applyStimulus(1'b1, 16'h007E, 1'b0);
        checkAll("err1", 1'b1, 1'b1, 16'd1, 16'd1);
        applyStimulus(1'b0, 16'h0000, 1'b0);
        checkAll("err1.gap", 1'b1, 1'b0, 16'd1, 16'd1);
        applyStimulus(1'b1, 16'h00FF, 1'b0);
        checkAll("err1.recover", 1'b1, 1'b0, 16'd1, 16'd1);
        applyStimulus(1'b0, 16'hAAAA, 1'b0);
        applyStimulus(1'b1, 16'h01FF, 1'b0);
        applyStimulus(1'b0, 16'h5555, 1'b0);
        applyStimulus(1'b0, 16'h1234, 1'b0);
        applyStimulus(1'b1, 16'h03FF, 1'b0);
        checkAll("gaps", 1'b1, 1'b0, 16'd1, 16'd1);

        // Loss of lock after three zero words
        doReset();
        feedChain("relock1", 16'h0003, 5, 5, bref);
        applyStimulus(1'b1, 16'h0000, 1'b0);
        checkAll("loss1", 1'b1, 1'b1, 16'd1, 16'd7);
        applyStimulus(1'b1, 16'h0000, 1'b0);
        checkAll("loss2", 1'b1, 1'b1, 16'd2, 16'd15);
        applyStimulus(1'b1, 16'h0000, 1'b0);
        checkAll("loss3", 1'b0, 1'b1, 16'd3, 16'd24);
        applyStimulus(1'b1, 16'h0005, 1'b0);
        checkAll("hunt.noerr", 1'b0, 1'b0, 16'd3, 16'd24);

        // Three matches, a wrong word, then a fresh run of four
        feedChain("run3", 16'h0003, 4, 99, bref);
        applyStimulus(1'b1, 16'h0055, 1'b0);
        checkAll("run.broken", 1'b0, 1'b0, 16'd3, 16'd24);
        feedChain("run4", nextWord(16'h0055), 4, 4, bref);
        checkAll("run4.done", 1'b1, 1'b0, 16'd3, 16'd24);

        // Saturation of both counters
        @(negedge clk);
        force dut.errCount_q = 16'hFFFE;
        force dut.bitErrs_q  = 16'hFFFA;
        #1;
        release dut.errCount_q;
        release dut.bitErrs_q;
        d = nextWord(bref) ^ 16'h00FF; bref = nextWord(bref);
        applyStimulus(1'b1, d, 1'b0);
        checkAll("sat1", 1'b1, 1'b1, 16'hFFFF, 16'hFFFF);
        d = nextWord(bref) ^ 16'h0001; bref = nextWord(bref);
        applyStimulus(1'b1, d, 1'b0);
        checkAll("sat2", 1'b1, 1'b1, 16'hFFFF, 16'hFFFF);
        d = nextWord(bref) ^ 16'h0001; bref = nextWord(bref);
        applyStimulus(1'b1, d, 1'b0);
        checkAll("sat3", 1'b0, 1'b1, 16'hFFFF, 16'hFFFF);

        // Clear coinciding with an error beat, then clear while idle
        feedChain("relock2", 16'h0003, 5, 5, bref);
        d = nextWord(bref) ^ 16'h0001; bref = nextWord(bref);
        applyStimulus(1'b1, d, 1'b1);
        checkAll("clr.err", 1'b1, 1'b1, 16'd0, 16'd0);
        d = nextWord(bref); bref = d;
        applyStimulus(1'b1, d, 1'b0);
        checkAll("clr.after", 1'b1, 1'b0, 16'd0, 16'd0);
        d = nextWord(bref) ^ 16'h0003; bref = nextWord(bref);
        applyStimulus(1'b1, d, 1'b0);
        checkAll("clr.preerr", 1'b1, 1'b1, 16'd1, 16'd2);
        applyStimulus(1'b0, 16'h0000, 1'b1);
        checkAll("clr.idle", 1'b1, 1'b0, 16'd0, 16'd0);

        // Asynchronous reset mid-cycle while locked
        d = nextWord(bref) ^ 16'h0001; bref = nextWord(bref);
        applyStimulus(1'b1, d, 1'b0);
        checkAll("prerst", 1'b1, 1'b1, 16'd1, 16'd1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1 checkAll("midrst", 1'b0, 1'b0, 16'd0, 16'd0);
        @(negedge clk);
        rst = 1'b0;
        feedChain("relock3", 16'h0003, 5, 5, bref);
        checkAll("relock3.done", 1'b1, 1'b0, 16'd0, 16'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
